// File: rtl/player_link_framer.sv
`default_nettype none
// ============================================================================
//  Module   : player_link_framer
//  Purpose  : Frames the local player state (x, y, level, skin) into a
//             byte-wide packet for a UART transmitter, and parses incoming
//             packets into the remote player state.
//             Frame on the wire is: SYNC_BYTE, payload bytes 0..NB-1, then
//             the 8-bit modular sum of the payload bytes.
//             The payload is packed LSB first (x, y, level, skin) and
//             zero-padded to a whole number of bytes.
//             Also tracks link health: link_up and an error counter.
//  Ports    : clk, rst (sync, active-low)
//             TX side : send_req, x/y/level/skin_local -> tx_data, tx_valid,
//                       tx_ready (handshake), tx_busy
//             RX side : rx_data, rx_valid -> x/y/level/skin_remote,
//                       remote_valid, link_up, err_cnt
//  Revision : 1.0  initial release
// ============================================================================
module player_link_framer #(
    parameter int         X_W          = 12,
    parameter int         Y_W          = 12,
    parameter int         LVL_W        = 2,
    parameter int         SKIN_W       = 3,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         GAP_CYC      = 20000,
    parameter int         LINK_TIMEOUT = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send_req,
    input  logic [X_W-1:0]    x_local,
    input  logic [Y_W-1:0]    y_local,
    input  logic [LVL_W-1:0]  level_local,
    input  logic [SKIN_W-1:0] skin_local,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_busy,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [X_W-1:0]    x_remote,
    output logic [Y_W-1:0]    y_remote,
    output logic [LVL_W-1:0]  level_remote,
    output logic [SKIN_W-1:0] skin_remote,
    output logic              remote_valid,
    output logic              link_up,
    output logic [7:0]        err_cnt
);

    localparam int c_PB    = X_W + Y_W + LVL_W + SKIN_W;
    localparam int c_NB    = (c_PB + 7) / 8;
    localparam int c_BW    = c_NB * 8;
    localparam int c_IDX_W = (c_NB > 1) ? $clog2(c_NB) : 1;
    localparam int c_GAP_W = $clog2(GAP_CYC + 1);
    localparam int c_WD_W  = $clog2(LINK_TIMEOUT + 1);

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_NB - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYC - 1);
    localparam logic [c_WD_W-1:0]  c_WD_MAX   = c_WD_W'(LINK_TIMEOUT);
    localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(LINK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SYNC = 2'd1,
        TX_PAY  = 2'd2,
        TX_CSUM = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_HUNT = 2'd0,
        RX_PAY  = 2'd1,
        RX_CSUM = 2'd2
    } rx_state_t;

    // ------------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------------
    tx_state_t            r_tx_state;
    tx_state_t            w_tx_next;
    logic                 r_pending;
    logic [c_BW-1:0]      r_tx_buf;      // payload snapshot, shifted down per byte
    logic [7:0]           r_tx_csum;
    logic [c_IDX_W-1:0]   r_tx_idx;
    logic [c_BW-1:0]      w_tx_payload;
    logic [7:0]           w_tx_sum;
    logic                 w_frame_start;
    logic [7:0]           w_tx_data;
    logic                 w_tx_valid;

    // Packed payload and its checksum, built straight from the live inputs;
    // only captured on the frame-start edge.
    always_comb begin
        w_tx_payload            = '0;
        w_tx_payload[c_PB-1:0]  = {skin_local, level_local, y_local, x_local};
        w_tx_sum                = 8'h00;
        for (int k = 0; k < c_NB; k++) begin
            w_tx_sum = w_tx_sum + w_tx_payload[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tx_state <= TX_IDLE;
        end else begin
            r_tx_state <= w_tx_next;
        end
    end

    always_comb begin
        w_tx_next     = r_tx_state;
        w_frame_start = 1'b0;
        w_tx_data     = 8'h00;
        w_tx_valid    = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (send_req || r_pending) begin
                    w_tx_next     = TX_SYNC;
                    w_frame_start = 1'b1;
                end
            end
            TX_SYNC: begin
                w_tx_valid = 1'b1;
                w_tx_data  = SYNC_BYTE;
                if (tx_ready) begin
                    w_tx_next = TX_PAY;
                end
            end
            TX_PAY: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_tx_buf[7:0];
                if (tx_ready && (r_tx_idx == c_IDX_LAST)) begin
                    w_tx_next = TX_CSUM;
                end
            end
            TX_CSUM: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_tx_csum;
                if (tx_ready) begin
                    // A queued request chains straight into the next frame.
                    if (r_pending) begin
                        w_tx_next     = TX_SYNC;
                        w_frame_start = 1'b1;
                    end else begin
                        w_tx_next = TX_IDLE;
                    end
                end
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pending <= 1'b0;
            r_tx_buf  <= '0;
            r_tx_csum <= 8'h00;
            r_tx_idx  <= '0;
        end else begin
            if (w_frame_start) begin
                r_tx_buf  <= w_tx_payload;
                r_tx_csum <= w_tx_sum;
                r_tx_idx  <= '0;
            end else if ((r_tx_state == TX_PAY) && tx_ready) begin
                r_tx_buf <= r_tx_buf >> 8;
                r_tx_idx <= r_tx_idx + c_IDX_W'(1);
            end
            // A request coinciding with a frame start is consumed by it.
            if (w_frame_start) begin
                r_pending <= 1'b0;
            end else if (send_req) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign tx_data  = w_tx_data;
    assign tx_valid = w_tx_valid;
    assign tx_busy  = (r_tx_state != TX_IDLE) || r_pending;

    // ------------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------------
    rx_state_t            r_rx_state;
    rx_state_t            w_rx_next;
    logic [c_PB-1:0]      r_rx_buf;      // only real payload bits; padding is dropped
    logic [7:0]           r_rx_sum;
    logic [c_IDX_W-1:0]   r_rx_idx;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic [c_WD_W-1:0]    r_wd_cnt;
    logic [X_W-1:0]       r_x_remote;
    logic [Y_W-1:0]       r_y_remote;
    logic [LVL_W-1:0]     r_level_remote;
    logic [SKIN_W-1:0]    r_skin_remote;
    logic                 r_remote_valid;
    logic                 r_link_up;
    logic [7:0]           r_err_cnt;
    logic                 w_good;
    logic                 w_bad;
    logic                 w_gap_hit;

    assign w_gap_hit = (r_gap_cnt == c_GAP_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_state <= RX_HUNT;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    always_comb begin
        w_rx_next = r_rx_state;
        w_good    = 1'b0;
        w_bad     = 1'b0;
        case (r_rx_state)
            RX_HUNT: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    w_rx_next = RX_PAY;
                end
            end
            RX_PAY: begin
                if (rx_valid) begin
                    if (r_rx_idx == c_IDX_LAST) begin
                        w_rx_next = RX_CSUM;
                    end
                end else if (w_gap_hit) begin
                    w_rx_next = RX_HUNT;
                    w_bad     = 1'b1;
                end
            end
            RX_CSUM: begin
                if (rx_valid) begin
                    w_rx_next = RX_HUNT;
                    if (rx_data == r_rx_sum) begin
                        w_good = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                end else if (w_gap_hit) begin
                    w_rx_next = RX_HUNT;
                    w_bad     = 1'b1;
                end
            end
            default: w_rx_next = RX_HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_buf       <= '0;
            r_rx_sum       <= 8'h00;
            r_rx_idx       <= '0;
            r_gap_cnt      <= '0;
            r_wd_cnt       <= '0;
            r_x_remote     <= '0;
            r_y_remote     <= '0;
            r_level_remote <= '0;
            r_skin_remote  <= '0;
            r_remote_valid <= 1'b0;
            r_link_up      <= 1'b0;
            r_err_cnt      <= 8'h00;
        end else begin
            if (r_rx_state == RX_HUNT) begin
                r_rx_idx <= '0;
                r_rx_sum <= 8'h00;
            end else if ((r_rx_state == RX_PAY) && rx_valid) begin
                // Each payload bit lands in the byte lane selected by the index;
                // padding bits of the last byte have no storage.
                for (int b = 0; b < c_PB; b++) begin
                    if (r_rx_idx == c_IDX_W'(b / 8)) begin
                        r_rx_buf[b] <= rx_data[b % 8];
                    end
                end
                r_rx_sum <= r_rx_sum + rx_data;
                r_rx_idx <= r_rx_idx + c_IDX_W'(1);
            end

            if ((r_rx_state == RX_HUNT) || rx_valid) begin
                r_gap_cnt <= '0;
            end else begin
                r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
            end

            if (w_good) begin
                r_x_remote     <= r_rx_buf[X_W-1:0];
                r_y_remote     <= r_rx_buf[X_W +: Y_W];
                r_level_remote <= r_rx_buf[X_W+Y_W +: LVL_W];
                r_skin_remote  <= r_rx_buf[X_W+Y_W+LVL_W +: SKIN_W];
            end
            r_remote_valid <= w_good;

            if (w_bad && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end

            // Link watchdog: saturates at the timeout so link_up stays low.
            if (w_good) begin
                r_wd_cnt  <= '0;
                r_link_up <= 1'b1;
            end else if (r_wd_cnt != c_WD_MAX) begin
                r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
                if (r_wd_cnt == c_WD_LAST) begin
                    r_link_up <= 1'b0;
                end
            end else begin
                r_link_up <= 1'b0;
            end
        end
    end

    assign x_remote     = r_x_remote;
    assign y_remote     = r_y_remote;
    assign level_remote = r_level_remote;
    assign skin_remote  = r_skin_remote;
    assign remote_valid = r_remote_valid;
    assign link_up      = r_link_up;
    assign err_cnt      = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_player_link_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_player_link_framer
//  Purpose  : Directed self-checking bench for player_link_framer. Expected
//             TX bytes and remote updates are queued when stimulus is driven
//             and compared when the DUT produces them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_player_link_framer;

    localparam int c_GAP = 40;
    localparam int c_LTO = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        send_req;
    logic [11:0] x_local, y_local;
    logic [1:0]  level_local;
    logic [2:0]  skin_local;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, tx_busy;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [11:0] x_remote, y_remote;
    logic [1:0]  level_remote;
    logic [2:0]  skin_remote;
    logic        remote_valid, link_up;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    player_link_framer #(
        .GAP_CYC      (c_GAP),
        .LINK_TIMEOUT (c_LTO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .send_req     (send_req),
        .x_local      (x_local),
        .y_local      (y_local),
        .level_local  (level_local),
        .skin_local   (skin_local),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_busy      (tx_busy),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .x_remote     (x_remote),
        .y_remote     (y_remote),
        .level_remote (level_remote),
        .skin_remote  (skin_remote),
        .remote_valid (remote_valid),
        .link_up      (link_up),
        .err_cnt      (err_cnt)
    );

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [1:0]  l;
        logic [2:0]  s;
    } rem_t;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] tx_q[$];
    rem_t       rx_q[$];
    logic       hold = 1'b0;
    logic [7:0] hold_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pay(input logic [11:0] x, input logic [11:0] y,
                                        input logic [1:0] l, input logic [2:0] s);
        return {3'b000, s, l, y, x};
    endfunction

    function automatic logic [7:0] psum(input logic [31:0] p);
        logic [7:0] sum;
        sum = 8'h00;
        for (int k = 0; k < 4; k++) sum = sum + p[8*k +: 8];
        return sum;
    endfunction

    task automatic push_frame(input logic [11:0] x, input logic [11:0] y,
                              input logic [1:0] l, input logic [2:0] s);
        logic [31:0] p;
        p = pay(x, y, l, s);
        tx_q.push_back(8'hA5);
        for (int k = 0; k < 4; k++) tx_q.push_back(p[8*k +: 8]);
        tx_q.push_back(psum(p));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic rx_frame(input logic [11:0] x, input logic [11:0] y,
                            input logic [1:0] l, input logic [2:0] s,
                            input logic [7:0] csum_xor, input bit good);
        logic [31:0] p;
        rem_t        e;
        p = pay(x, y, l, s);
        rx_send(8'hA5);
        for (int k = 0; k < 4; k++) rx_send(p[8*k +: 8]);
        if (good) begin
            e.x = x; e.y = y; e.l = l; e.s = s;
            rx_q.push_back(e);
        end
        rx_send(psum(p) ^ csum_xor);
    endtask

    task automatic chk_remote();
        rem_t e;
        e = rx_q.pop_front();
        chk("rx_upd_x", {20'h0, x_remote}, {20'h0, e.x});
        chk("rx_upd_y", {20'h0, y_remote}, {20'h0, e.y});
        chk("rx_upd_level", {30'h0, level_remote}, {30'h0, e.l});
        chk("rx_upd_skin", {29'h0, skin_remote}, {29'h0, e.s});
    endtask

    // Monitor: sampled on the falling edge, between driver updates.
    always @(negedge clk) begin
        if (rst) begin
            if (hold && tx_valid) chk("tx_hold_stable", {24'h0, tx_data}, {24'h0, hold_data});
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) chk("tx_extra_byte", {31'h0, tx_valid}, 32'd0);
                else chk("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
            end
            hold      <= tx_valid && !tx_ready;
            hold_data <= tx_data;
            if (remote_valid) begin
                if (rx_q.size() == 0) chk("rx_extra_update", {31'h0, remote_valid}, 32'd0);
                else chk_remote();
            end
        end else begin
            hold <= 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        rst = 1'b0; send_req = 1'b0; tx_ready = 1'b1;
        x_local = '0; y_local = '0; level_local = '0; skin_local = '0;
        rx_data = 8'h00; rx_valid = 1'b0;
        repeat (3) tick();
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'd0);
        chk("rst_tx_busy", {31'h0, tx_busy}, 32'd0);
        chk("rst_link_up", {31'h0, link_up}, 32'd0);
        chk("rst_err_cnt", {24'h0, err_cnt}, 32'd0);
        chk("rst_remote_valid", {31'h0, remote_valid}, 32'd0);
        chk("rst_x_remote", {20'h0, x_remote}, 32'd0);
        rst = 1'b1;
        tick();

        // Frame with the reference bytes, tx_ready held high.
        x_local = 12'h123; y_local = 12'h0AB; level_local = 2'd2; skin_local = 3'd5;
        tx_q.push_back(8'hA5); tx_q.push_back(8'h23); tx_q.push_back(8'hB1);
        tx_q.push_back(8'h0A); tx_q.push_back(8'h16); tx_q.push_back(8'hF4);
        send_req = 1'b1; tick(); send_req = 1'b0;
        repeat (5) tick();
        chk("tx_busy_mid", {31'h0, tx_busy}, 32'd1);
        tick();
        chk("tx_busy_done", {31'h0, tx_busy}, 32'd0);
        chk("tx_q_empty_1", tx_q.size(), 32'd0);

        // Same frame with tx_ready toggling, inputs changed after the snapshot.
        push_frame(12'h123, 12'h0AB, 2'd2, 3'd5);
        tx_ready = 1'b0;
        send_req = 1'b1; tick(); send_req = 1'b0;
        x_local = 12'hFFF; y_local = 12'h000; level_local = 2'd1; skin_local = 3'd0;
        for (int i = 0; i < 16; i++) begin
            tx_ready = ~tx_ready;
            tick();
        end
        tx_ready = 1'b1;
        chk("tx_busy_stall_done", {31'h0, tx_busy}, 32'd0);
        chk("tx_q_empty_2", tx_q.size(), 32'd0);

        // Requests during a frame merge into one follow-on frame.
        x_local = 12'h456; y_local = 12'h789; level_local = 2'd1; skin_local = 3'd2;
        push_frame(12'h456, 12'h789, 2'd1, 3'd2);
        send_req = 1'b1; tick();                                     // frame start
        x_local = 12'hDEF; y_local = 12'h321; level_local = 2'd3; skin_local = 3'd7;
        push_frame(12'hDEF, 12'h321, 2'd3, 3'd7);
        send_req = 1'b1; tick();
        send_req = 1'b0; tick();
        send_req = 1'b1; tick();
        send_req = 1'b0; tick();
        send_req = 1'b1; tick();
        send_req = 1'b0; tick();                                     // checksum accepted
        chk("pend_restart_valid", {31'h0, tx_valid}, 32'd1);
        chk("pend_restart_sync", {24'h0, tx_data}, 32'hA5);
        repeat (6) tick();
        chk("pend_busy_done", {31'h0, tx_busy}, 32'd0);
        repeat (3) tick();
        chk("pend_no_third_frame", {31'h0, tx_valid}, 32'd0);
        chk("tx_q_empty_3", tx_q.size(), 32'd0);

        // Good RX frame after a noise byte, with a TX request in the same cycle.
        x_local = 12'h111; y_local = 12'h222; level_local = 2'd0; skin_local = 3'd1;
        push_frame(12'h111, 12'h222, 2'd0, 3'd1);
        send_req = 1'b1; rx_data = 8'h00; rx_valid = 1'b1;
        tick();
        send_req = 1'b0; rx_valid = 1'b0;
        rx_frame(12'h123, 12'h0AB, 2'd2, 3'd5, 8'h00, 1'b1);
        chk("rx_good_x", {20'h0, x_remote}, 32'h123);
        chk("rx_good_y", {20'h0, y_remote}, 32'h0AB);
        chk("rx_good_level", {30'h0, level_remote}, 32'd2);
        chk("rx_good_skin", {29'h0, skin_remote}, 32'd5);
        chk("rx_good_pulse", {31'h0, remote_valid}, 32'd1);
        chk("rx_good_link", {31'h0, link_up}, 32'd1);
        tick();
        chk("rx_pulse_end", {31'h0, remote_valid}, 32'd0);
        chk("tx_q_empty_4", tx_q.size(), 32'd0);

        // Bad checksum (F5).
        rx_frame(12'h123, 12'h0AB, 2'd2, 3'd5, 8'h01, 1'b0);
        chk("bad_csum_err", {24'h0, err_cnt}, 32'd1);
        chk("bad_csum_x", {20'h0, x_remote}, 32'h123);

        // Gap timeout inside a frame.
        rx_send(8'hA5);
        rx_send(8'h23);
        repeat (c_GAP - 2) tick();
        chk("gap_before_err", {24'h0, err_cnt}, 32'd1);
        repeat (4) tick();
        chk("gap_after_err", {24'h0, err_cnt}, 32'd2);
        rx_frame(12'hABC, 12'h456, 2'd1, 3'd3, 8'h00, 1'b1);
        chk("gap_recover_x", {20'h0, x_remote}, 32'hABC);
        chk("gap_recover_skin", {29'h0, skin_remote}, 32'd3);

        // Link watchdog.
        repeat (c_LTO - 2) tick();
        chk("link_before_to", {31'h0, link_up}, 32'd1);
        repeat (4) tick();
        chk("link_after_to", {31'h0, link_up}, 32'd0);
        chk("link_to_hold_y", {20'h0, y_remote}, 32'h456);

        // Error counter saturation.
        for (int i = 0; i < 200; i++) rx_frame(12'h000, 12'h000, 2'd0, 3'd0, 8'h01, 1'b0);
        chk("err_cnt_202", {24'h0, err_cnt}, 32'd202);
        for (int i = 0; i < 60; i++) rx_frame(12'h000, 12'h000, 2'd0, 3'd0, 8'h01, 1'b0);
        chk("err_cnt_sat", {24'h0, err_cnt}, 32'd255);
        chk("err_hold_x", {20'h0, x_remote}, 32'hABC);

        // Reset in the middle of a frame.
        x_local = 12'h0F0; y_local = 12'h00F; level_local = 2'd1; skin_local = 3'd6;
        push_frame(12'h0F0, 12'h00F, 2'd1, 3'd6);
        send_req = 1'b1; tick(); send_req = 1'b0;
        tick();
        tick();
        rst = 1'b0; tx_ready = 1'b0;
        tick();
        tx_q.delete();
        chk("mid_rst_tx_valid", {31'h0, tx_valid}, 32'd0);
        chk("mid_rst_tx_data", {24'h0, tx_data}, 32'd0);
        chk("mid_rst_tx_busy", {31'h0, tx_busy}, 32'd0);
        chk("mid_rst_err", {24'h0, err_cnt}, 32'd0);
        chk("mid_rst_x", {20'h0, x_remote}, 32'd0);
        chk("mid_rst_skin", {29'h0, skin_remote}, 32'd0);
        rst = 1'b1; tx_ready = 1'b1;
        repeat (3) tick();
        chk("post_rst_quiet", {31'h0, tx_valid}, 32'd0);

        chk("final_tx_q", tx_q.size(), 32'd0);
        chk("final_rx_q", rx_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
